// File: rtl/fetch_run_controller.sv
// fetch_run_controller
// -----------------------------------------------------------------------------
// Run-control sequencer for the MIPS instruction-fetch stage. It receives a
// program as a byte stream, packs the bytes MSB-first into words and writes
// them to instruction memory. When loading is done it clears the PC and lets
// the PC advance, either continuously or one instruction per step pulse. It
// stops when the fetched instruction is the HALT word.
//
// Ports
//   i_clk, i_rst         clock and asynchronous active-high reset
//   i_load_start         pulse: begin a program load (IDLE, READY or HALTED)
//   i_load_valid/_byte   byte stream; consumed only while o_load_ready=1
//   o_load_ready         a byte is accepted this cycle
//   i_start, i_mode_step start execution (READY or HALTED); 1 = step mode
//   i_step               single-step pulse (honoured in step mode only)
//   i_instruccion        instruction currently at the fetch output
//   o_im_wr_en/_addr/_data  instruction memory write port
//   o_pc_reset           one-cycle PC clear, in the cycle the start is taken
//   o_pc_enable          PC advance enable (combinational)
//   o_halted             execution stopped on the HALT word
//   o_cycle_count        cycles with o_pc_enable=1 since the last start
// -----------------------------------------------------------------------------
module fetch_run_controller #(
    parameter int              len       = 32,
    parameter int              IM_DEPTH  = 64,
    parameter int              ADDR_W    = 6,
    parameter logic [len-1:0]  HALT_WORD = {len{1'b1}}
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load_start,
    input  logic              i_load_valid,
    input  logic [7:0]        i_load_byte,
    output logic              o_load_ready,
    input  logic              i_start,
    input  logic              i_mode_step,
    input  logic              i_step,
    input  logic [len-1:0]    i_instruccion,
    output logic              o_im_wr_en,
    output logic [ADDR_W-1:0] o_im_addr,
    output logic [len-1:0]    o_im_data,
    output logic              o_pc_reset,
    output logic              o_pc_enable,
    output logic              o_halted,
    output logic [len-1:0]    o_cycle_count
);

    localparam int BPW   = len / 8;                // bytes per word
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IM_DEPTH - 1);
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BPW - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        READY,
        RUN,
        STEP,
        HALTED
    } state_t;

    state_t            state_reg, state_next;
    logic [len-1:0]    word_reg, word_next;
    logic [CNT_W-1:0]  byte_cnt_reg, byte_cnt_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [len-1:0]    cycle_count_reg, cycle_count_next;

    logic instr_is_halt;
    logic load_ready;
    logic im_wr_en;
    logic pc_reset;
    logic pc_enable;

    assign instr_is_halt = (i_instruccion == HALT_WORD);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg       <= IDLE;
            word_reg        <= '0;
            byte_cnt_reg    <= '0;
            addr_reg        <= '0;
            cycle_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            word_reg        <= word_next;
            byte_cnt_reg    <= byte_cnt_next;
            addr_reg        <= addr_next;
            cycle_count_reg <= cycle_count_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        word_next        = word_reg;
        byte_cnt_next    = byte_cnt_reg;
        addr_next        = addr_reg;
        cycle_count_next = cycle_count_reg;
        load_ready       = 1'b0;
        im_wr_en         = 1'b0;
        pc_reset         = 1'b0;
        pc_enable        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (i_load_start) begin
                    state_next    = LOAD;
                    word_next     = '0;
                    byte_cnt_next = '0;
                    addr_next     = '0;
                end
            end

            LOAD: begin
                load_ready = 1'b1;
                if (i_load_valid) begin
                    word_next = {word_reg[len-9:0], i_load_byte};
                    if (byte_cnt_reg == LAST_BYTE) begin
                        byte_cnt_next = '0;
                        state_next    = WRITE;
                    end else begin
                        byte_cnt_next = byte_cnt_reg + CNT_W'(1);
                    end
                end
            end

            WRITE: begin
                im_wr_en = 1'b1;
                // The HALT word itself is stored, then loading ends. Loading
                // also ends at the last memory word so the address never wraps.
                if (word_reg == HALT_WORD || addr_reg == LAST_ADDR) begin
                    state_next = READY;
                end else begin
                    addr_next  = addr_reg + ADDR_W'(1);
                    state_next = LOAD;
                end
            end

            READY, HALTED: begin
                // A load request wins over a start in the same cycle.
                if (i_load_start) begin
                    state_next    = LOAD;
                    word_next     = '0;
                    byte_cnt_next = '0;
                    addr_next     = '0;
                end else if (i_start) begin
                    pc_reset         = 1'b1;
                    cycle_count_next = '0;
                    state_next       = i_mode_step ? STEP : RUN;
                end
            end

            RUN: begin
                pc_enable = !instr_is_halt;
                if (instr_is_halt) begin
                    state_next = HALTED;
                end
            end

            STEP: begin
                pc_enable = i_step && !instr_is_halt;
                if (instr_is_halt) begin
                    state_next = HALTED;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Only RUN/STEP raise pc_enable, so this never collides with the
        // clear performed on start.
        if (pc_enable) begin
            cycle_count_next = cycle_count_reg + len'(1);
        end
    end

    assign o_load_ready  = load_ready;
    assign o_im_wr_en    = im_wr_en;
    assign o_im_addr     = addr_reg;
    // Write data is only driven while the write strobe is up, so the bus
    // stays quiet while a word is still being assembled.
    assign o_im_data     = im_wr_en ? word_reg : '0;
    assign o_pc_reset    = pc_reset;
    assign o_pc_enable   = pc_enable;
    assign o_halted      = (state_reg == HALTED);
    assign o_cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_fetch_run_controller.sv
// Testbench for fetch_run_controller: a table of per-cycle vectors covers
// reset, a short program load, continuous run and step mode; hand-written
// sequences cover the full-memory load, load/start priority and reset in the
// middle of a word and in the middle of a run.
module tb_fetch_run_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start, load_valid, start, mode_step, step;
    logic [7:0]  load_byte;
    logic [31:0] instr;
    logic        load_ready, im_wr_en, pc_reset, pc_enable, halted;
    logic [5:0]  im_addr;
    logic [31:0] im_data, cycle_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_run_controller dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_load_start  (load_start),
        .i_load_valid  (load_valid),
        .i_load_byte   (load_byte),
        .o_load_ready  (load_ready),
        .i_start       (start),
        .i_mode_step   (mode_step),
        .i_step        (step),
        .i_instruccion (instr),
        .o_im_wr_en    (im_wr_en),
        .o_im_addr     (im_addr),
        .o_im_data     (im_data),
        .o_pc_reset    (pc_reset),
        .o_pc_enable   (pc_enable),
        .o_halted      (halted),
        .o_cycle_count (cycle_count)
    );

    typedef struct {
        logic        ls, lv;
        logic [7:0]  lb;
        logic        st, ms, sp;
        logic [31:0] ins;
        logic        e_rdy, e_wr;
        logic [5:0]  e_addr;
        logic [31:0] e_data;
        logic        e_pcr, e_pce, e_hlt;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic ls, logic lv, logic [7:0] lb, logic st, logic ms,
                                logic sp, logic [31:0] ins, logic e_rdy, logic e_wr,
                                logic [5:0] e_addr, logic [31:0] e_data, logic e_pcr,
                                logic e_pce, logic e_hlt, logic [31:0] e_cnt);
        vec_t v;
        v.ls = ls; v.lv = lv; v.lb = lb; v.st = st; v.ms = ms; v.sp = sp; v.ins = ins;
        v.e_rdy = e_rdy; v.e_wr = e_wr; v.e_addr = e_addr; v.e_data = e_data;
        v.e_pcr = e_pcr; v.e_pce = e_pce; v.e_hlt = e_hlt; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then let combinational
    // outputs settle before the caller samples them.
    task automatic drive(input logic ls, input logic lv, input logic [7:0] lb, input logic st,
                         input logic ms, input logic sp, input logic [31:0] ins);
        @(negedge clk);
        load_start = ls; load_valid = lv; load_byte = lb;
        start = st; mode_step = ms; step = sp; instr = ins;
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " rdy"},  32'(load_ready), 32'd0);
        chk({tag, " wr"},   32'(im_wr_en),   32'd0);
        chk({tag, " addr"}, 32'(im_addr),    32'd0);
        chk({tag, " data"}, im_data,         32'd0);
        chk({tag, " pcr"},  32'(pc_reset),   32'd0);
        chk({tag, " pce"},  32'(pc_enable),  32'd0);
        chk({tag, " hlt"},  32'(halted),     32'd0);
        chk({tag, " cnt"},  cycle_count,     32'd0);
    endtask

    // Feed one 32-bit word MSB-first, then check the resulting write cycle.
    task automatic load_word(input logic [31:0] w, input logic [5:0] a, input string tag);
        logic [31:0] tmp;
        tmp = w;
        for (int j = 0; j < 4; j++) begin
            drive(0, 1, tmp[31:24], 0, 0, 0, 32'h0);
            chk($sformatf("%s rdy a%0d b%0d", tag, a, j), 32'(load_ready), 32'd1);
            chk($sformatf("%s wr0 a%0d b%0d", tag, a, j), 32'(im_wr_en), 32'd0);
            tmp = tmp << 8;
        end
        // A byte offered during the write cycle must be ignored.
        drive(0, 1, 8'hEE, 0, 0, 0, 32'h0);
        chk($sformatf("%s wr a%0d", tag, a),   32'(im_wr_en),   32'd1);
        chk($sformatf("%s rdy0 a%0d", tag, a), 32'(load_ready), 32'd0);
        chk($sformatf("%s addr a%0d", tag, a), 32'(im_addr),    32'(a));
        chk($sformatf("%s data a%0d", tag, a), im_data,         w);
        $display("write %s addr=%0d data=%h", tag, im_addr, im_data);
    endtask

    localparam logic [31:0] H = 32'hFFFF_FFFF;

    initial begin
        rst = 1'b1;
        load_start = 0; load_valid = 0; load_byte = 0;
        start = 0; mode_step = 0; step = 0; instr = 0;

        //    ls lv lb     st ms sp ins            rdy wr addr data          pcr pce hlt cnt
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 0)); // 0 idle
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 0)); // 1 load start
        tbl.push_back(mk(0, 1, 8'h11, 0, 0, 0, 32'h0,        1, 0, 0, 32'h0,        0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h22, 0, 0, 0, 32'h0,        1, 0, 0, 32'h0,        0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h33, 0, 0, 0, 32'h0,        1, 0, 0, 32'h0,        0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h44, 0, 0, 0, 32'h0,        1, 0, 0, 32'h0,        0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 32'h0,        0, 1, 0, 32'h11223344, 0, 0, 0, 0)); // 6 write 0
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 32'h0,        1, 0, 1, 32'h0,        0, 0, 0, 0)); // 7 idle byte gap
        tbl.push_back(mk(0, 1, 8'h55, 0, 0, 0, 32'h0,        1, 0, 1, 32'h0,        0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h66, 0, 0, 0, 32'h0,        1, 0, 1, 32'h0,        0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h77, 0, 0, 0, 32'h0,        1, 0, 1, 32'h0,        0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h88, 0, 0, 0, 32'h0,        1, 0, 1, 32'h0,        0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 32'h0,        0, 1, 1, 32'h55667788, 0, 0, 0, 0)); // 12 write 1
        tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 0, 32'h0,        1, 0, 2, 32'h0,        0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 0, 32'h0,        1, 0, 2, 32'h0,        0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 0, 32'h0,        1, 0, 2, 32'h0,        0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 0, 32'h0,        1, 0, 2, 32'h0,        0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 32'h0,        0, 1, 2, H,            0, 0, 0, 0)); // 17 write HALT
        tbl.push_back(mk(0, 1, 8'hAA, 0, 0, 1, 32'h0,        0, 0, 2, 32'h0,        0, 0, 0, 0)); // 18 READY ignores
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 32'h0,        0, 0, 2, 32'h0,        1, 0, 0, 0)); // 19 start cont
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 32'h11223344, 0, 0, 2, 32'h0,        0, 1, 0, 0)); // 20 run
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 32'h55667788, 0, 0, 2, 32'h0,        0, 1, 0, 1)); // 21 start ignored
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, H,            0, 0, 2, 32'h0,        0, 0, 0, 2)); // 22 HALT fetched
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, H,            0, 0, 2, 32'h0,        0, 0, 1, 2)); // 23 halted
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, H,            0, 0, 2, 32'h0,        1, 0, 1, 2)); // 24 start step
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 32'h11223344, 0, 0, 2, 32'h0,        0, 0, 0, 0)); // 25
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 32'h11223344, 0, 0, 2, 32'h0,        0, 1, 0, 0)); // 26 step 1
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 32'h55667788, 0, 0, 2, 32'h0,    0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 32'h55667788, 0, 0, 2, 32'h0,        0, 1, 0, 1)); // 31 step 2
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 32'h0000000C, 0, 0, 2, 32'h0,    0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 32'h0000000C, 0, 0, 2, 32'h0,        0, 1, 0, 2)); // 36 step 3
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, H,            0, 0, 2, 32'h0,        0, 0, 0, 3)); // 37 step on HALT
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, H,            0, 0, 2, 32'h0,        0, 0, 1, 3)); // 38 halted

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        for (int v = 0; v < tbl.size(); v++) begin
            drive(tbl[v].ls, tbl[v].lv, tbl[v].lb, tbl[v].st, tbl[v].ms, tbl[v].sp, tbl[v].ins);
            chk($sformatf("v%0d rdy", v),  32'(load_ready), 32'(tbl[v].e_rdy));
            chk($sformatf("v%0d wr", v),   32'(im_wr_en),   32'(tbl[v].e_wr));
            chk($sformatf("v%0d addr", v), 32'(im_addr),    32'(tbl[v].e_addr));
            chk($sformatf("v%0d data", v), im_data,         tbl[v].e_data);
            chk($sformatf("v%0d pcr", v),  32'(pc_reset),   32'(tbl[v].e_pcr));
            chk($sformatf("v%0d pce", v),  32'(pc_enable),  32'(tbl[v].e_pce));
            chk($sformatf("v%0d hlt", v),  32'(halted),     32'(tbl[v].e_hlt));
            chk($sformatf("v%0d cnt", v),  cycle_count,     tbl[v].e_cnt);
            $display("vec %0d rdy=%b wr=%b addr=%0d data=%h pcr=%b pce=%b hlt=%b cnt=%0d",
                     v, load_ready, im_wr_en, im_addr, im_data, pc_reset, pc_enable, halted,
                     cycle_count);
        end

        // Full-memory load from HALTED; load request beats start in the same cycle.
        drive(1, 0, 8'h00, 1, 0, 0, H);
        chk("prio halted pcr", 32'(pc_reset), 32'd0);
        for (int k = 0; k < 64; k++) begin
            logic [7:0] b0, b1, b2, b3;
            b0 = 8'(4 * k); b1 = 8'(4 * k + 1); b2 = 8'(4 * k + 2); b3 = 8'(4 * k + 3);
            load_word({b0, b1, b2, b3}, 6'(k), "full");
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 8'h5A, 0, 0, 0, 32'h0);
            chk($sformatf("full extra%0d rdy", i),  32'(load_ready), 32'd0);
            chk($sformatf("full extra%0d wr", i),   32'(im_wr_en),   32'd0);
            chk($sformatf("full extra%0d addr", i), 32'(im_addr),    32'd63);
        end
        drive(1, 0, 8'h00, 1, 0, 0, 32'h0);
        chk("prio ready pcr", 32'(pc_reset), 32'd0);
        drive(0, 0, 8'h00, 0, 0, 0, 32'h0);
        chk("prio ready -> LOAD rdy", 32'(load_ready), 32'd1);
        chk("prio ready -> LOAD addr", 32'(im_addr),   32'd0);
        chk("prio ready cnt kept", cycle_count,        32'd3);

        // Reset after two bytes of a word; the fresh load must realign.
        drive(0, 1, 8'hDE, 0, 0, 0, 32'h0);
        drive(0, 1, 8'hAD, 0, 0, 0, 32'h0);
        @(negedge clk);
        load_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_all_zero("midword rst");
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 8'h00, 0, 0, 0, 32'h0);
        load_word(32'hCAFEBABE, 6'd0, "reload");
        load_word(H, 6'd1, "reload");
        drive(0, 0, 8'h00, 0, 0, 0, 32'h0);
        chk("reload ready rdy", 32'(load_ready), 32'd0);

        // Run for three cycles, then reset in the middle of the run.
        drive(0, 0, 8'h00, 1, 0, 0, 32'h0);
        chk("run2 pcr", 32'(pc_reset), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 8'h00, 0, 0, 0, 32'h00000001);
            chk($sformatf("run2 pce%0d", i), 32'(pc_enable), 32'd1);
        end
        @(negedge clk);
        chk("run2 cnt", cycle_count, 32'd3);
        rst = 1'b1;
        #1;
        chk_all_zero("midrun rst");
        @(negedge clk);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
